// File: rtl/timer_periph.sv
// timer_periph: countdown timer on the single-master req/gnt register bus.
// A fixed-latency grant FSM commits LOAD/CONTROL/STATUS accesses.
module timer_periph #(
    parameter int unsigned                 P_ADDR_WIDTH   = 8,
    parameter int unsigned                 P_DATA_WIDTH   = 32,
    parameter logic [P_ADDR_WIDTH-1:0]     P_ADDR_LOAD    = 8'h00,
    parameter logic [P_ADDR_WIDTH-1:0]     P_ADDR_CONTROL = 8'h04,
    parameter logic [P_ADDR_WIDTH-1:0]     P_ADDR_STATUS  = 8'h08,
    parameter int unsigned                 P_GNT_DELAY    = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req,
    output logic                    gnt,
    input  logic [P_ADDR_WIDTH-1:0] addr,
    input  logic [P_DATA_WIDTH-1:0] wdata,
    input  logic                    write_en,
    output logic [P_DATA_WIDTH-1:0] rdata,
    output logic                    irq
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WAIT    = 2'd1;
    localparam logic [1:0] S_GRANT   = 2'd2;
    localparam logic [1:0] S_RELEASE = 2'd3;

    // WAIT spans P_GNT_DELAY-1 edges; the IDLE edge already counts as one
    localparam logic [2:0] WAIT_LAST =
        (P_GNT_DELAY >= 2) ? 3'(P_GNT_DELAY - 2) : 3'd0;

    localparam logic [P_DATA_WIDTH-1:0] ONE =
        {{(P_DATA_WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]              state_q, state_d;
    logic [2:0]              dly_q, dly_d;
    logic [P_DATA_WIDTH-1:0] load_q, load_d;
    logic [P_DATA_WIDTH-1:0] count_q, count_d;
    logic [2:0]              ctrl_q, ctrl_d;
    logic                    expired_q, expired_d;
    logic                    irq_q;

    logic commit;
    logic wr_load;
    logic wr_ctrl;
    logic wr_stat;
    logic enable;
    logic expire;
    logic running;

    always_comb begin
        state_d = state_q;
        dly_d   = dly_q;
        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    dly_d   = 3'd0;
                    state_d = (P_GNT_DELAY == 1) ? S_GRANT : S_WAIT;
                end
            end
            S_WAIT: begin
                if (!req) begin
                    state_d = S_IDLE;
                end else if (dly_q == WAIT_LAST) begin
                    state_d = S_GRANT;
                end else begin
                    dly_d = dly_q + 3'd1;
                end
            end
            S_GRANT: state_d = S_RELEASE;
            S_RELEASE: begin
                if (!req) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign gnt     = (state_q == S_GRANT);
    assign commit  = gnt & write_en;
    assign wr_load = commit & (addr == P_ADDR_LOAD);
    assign wr_ctrl = commit & (addr == P_ADDR_CONTROL);
    assign wr_stat = commit & (addr == P_ADDR_STATUS);

    assign enable  = ctrl_q[0];
    assign expire  = enable & (count_q == ONE);
    assign running = enable & (count_q != '0);

    // Bus writes are applied last so they win over the counter's own update
    always_comb begin
        load_d    = load_q;
        count_d   = count_q;
        ctrl_d    = ctrl_q;
        expired_d = expired_q;
        if (enable && count_q > ONE) begin
            count_d = count_q - ONE;
        end
        if (expire) begin
            expired_d = 1'b1;
            if (ctrl_q[1]) begin
                count_d = load_q;
            end else begin
                count_d   = '0;
                ctrl_d[0] = 1'b0;
            end
        end
        if (wr_load) begin
            load_d  = wdata;
            count_d = wdata;
        end
        if (wr_ctrl) begin
            ctrl_d = wdata[2:0];
        end
        if (wr_stat && wdata[0] && !expire) begin
            expired_d = 1'b0;
        end
    end

    always_comb begin
        rdata = '0;
        if (!write_en) begin
            unique case (1'b1)
                addr == P_ADDR_LOAD:    rdata      = load_q;
                addr == P_ADDR_CONTROL: rdata[2:0] = ctrl_q;
                addr == P_ADDR_STATUS:  rdata[1:0] = {running, expired_q};
                default:                rdata      = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            dly_q     <= 3'd0;
            load_q    <= '0;
            count_q   <= '0;
            ctrl_q    <= 3'd0;
            expired_q <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            dly_q     <= dly_d;
            load_q    <= load_d;
            count_q   <= count_d;
            ctrl_q    <= ctrl_d;
            expired_q <= expired_d;
            irq_q     <= expired_q & ctrl_q[2];
        end
    end

    assign irq = irq_q;

endmodule

// File: tb/tb_timer_periph.sv
// tb_timer_periph: vector table, directed corner sequences and
// randomized traffic checked against a cycle-level reference model.
module tb_timer_periph;

    localparam int D = 3;
    localparam logic [7:0] A_LOAD = 8'h00;
    localparam logic [7:0] A_CTRL = 8'h04;
    localparam logic [7:0] A_STAT = 8'h08;
    localparam logic [7:0] A_NONE = 8'h0C;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        gnt;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic        write_en;
    logic [31:0] rdata;
    logic        irq;

    int checks   = 0;
    int failures = 0;
    bit chk_on   = 1'b0;

    timer_periph #(.P_GNT_DELAY(D)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .gnt      (gnt),
        .addr     (addr),
        .wdata    (wdata),
        .write_en (write_en),
        .rdata    (rdata),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    // Reference model: m_age counts consecutive edges that sampled req=1,
    // so the single grant cycle is the one where m_age reaches D.
    logic [31:0] m_load, m_cnt;
    logic        m_en, m_rl, m_ie, m_exp, m_irq;
    int          m_age;
    logic        t_commit, t_fire;

    always @(posedge clk) begin
        if (reset) begin
            m_load = 0; m_cnt = 0;
            m_en = 0; m_rl = 0; m_ie = 0;
            m_exp = 0; m_irq = 0; m_age = 0;
        end else begin
            t_commit = (m_age == D) && write_en;
            t_fire   = m_en && (m_cnt == 1);
            m_irq    = m_exp && m_ie;
            if (m_en && m_cnt > 1) begin
                m_cnt = m_cnt - 1;
            end else if (t_fire) begin
                m_exp = 1;
                if (m_rl) m_cnt = m_load;
                else begin m_cnt = 0; m_en = 0; end
            end
            if (t_commit) begin
                case (addr)
                    A_LOAD: begin m_load = wdata; m_cnt = wdata; end
                    A_CTRL: {m_ie, m_rl, m_en} = wdata[2:0];
                    A_STAT: if (wdata[0] && !t_fire) m_exp = 0;
                    default: ;
                endcase
            end
            m_age = req ? (m_age < 1000 ? m_age + 1 : m_age) : 0;
        end
    end

    function automatic logic [31:0] exp_rd();
        if (write_en) return 32'h0;
        case (addr)
            A_LOAD:  return m_load;
            A_CTRL:  return {29'd0, m_ie, m_rl, m_en};
            A_STAT:  return {30'd0, m_en && (m_cnt != 0), m_exp};
            default: return 32'h0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s @%0t: got %h expected %h",
                     name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("model_gnt", 32'(gnt), 32'(m_age == D));
            chk("model_irq", 32'(irq), 32'(m_irq));
            chk("model_rdata", rdata, exp_rd());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starts right after an edge with the FSM idle; ends one edge after
    // the grant edge, by which time req=0 has returned the FSM to IDLE.
    task automatic xfer(input logic we, input logic [7:0] a,
                        input logic [31:0] d, output logic [31:0] rd);
        req = 1; write_en = we; addr = a; wdata = d;
        rd = 0;
        for (int i = 0; i <= D; i++) begin
            @(negedge clk);
            chk("xfer_gnt", 32'(gnt), 32'(i == D));
            rd = rdata;
            step();
        end
        req = 0; write_en = 0;
        step();
    endtask

    typedef struct {
        logic        we;
        logic [7:0]  a;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;

    vec_t        tbl[14];
    logic [31:0] rd;
    int          ng;

    initial begin
        tbl[0]  = '{1'b1, A_LOAD, 32'h1234_5678, 32'h0};
        tbl[1]  = '{1'b0, A_LOAD, 32'h0, 32'h1234_5678};
        tbl[2]  = '{1'b1, A_CTRL, 32'hFFFF_FFF8, 32'h0};
        tbl[3]  = '{1'b0, A_CTRL, 32'h0, 32'h0};
        tbl[4]  = '{1'b1, A_CTRL, 32'h6, 32'h0};
        tbl[5]  = '{1'b0, A_CTRL, 32'h0, 32'h6};
        tbl[6]  = '{1'b1, A_NONE, 32'h0000_FFFF, 32'h0};
        tbl[7]  = '{1'b0, A_NONE, 32'h0, 32'h0};
        tbl[8]  = '{1'b0, A_LOAD, 32'h0, 32'h1234_5678};
        tbl[9]  = '{1'b0, A_STAT, 32'h0, 32'h0};
        tbl[10] = '{1'b1, A_STAT, 32'hFFFF_FFFF, 32'h0};
        tbl[11] = '{1'b0, A_STAT, 32'h0, 32'h0};
        tbl[12] = '{1'b1, A_CTRL, 32'h0, 32'h0};
        tbl[13] = '{1'b0, A_CTRL, 32'h0, 32'h0};

        reset = 1; req = 0; write_en = 0; addr = A_LOAD; wdata = 0;
        step();
        chk_on = 1;
        @(negedge clk);
        chk("reset_gnt", 32'(gnt), 32'h0);
        chk("reset_irq", 32'(irq), 32'h0);
        chk("reset_rdata", rdata, 32'h0);
        step();
        reset = 0;

        for (int i = 0; i < 14; i++) begin
            xfer(tbl[i].we, tbl[i].a, tbl[i].d, rd);
            if (!tbl[i].we) chk($sformatf("tbl_%0d", i), rd, tbl[i].exp);
        end

        // one-shot: LOAD=5, CONTROL=irq_en|enable
        xfer(1, A_LOAD, 32'd5, rd);
        xfer(1, A_CTRL, 32'h5, rd);
        addr = A_STAT;
        @(negedge clk);
        chk("oneshot_run_e1", rdata, 32'h2);
        repeat (3) step();
        @(negedge clk);
        chk("oneshot_run_e4", rdata, 32'h2);
        step();
        @(negedge clk);
        chk("oneshot_expire_e5", rdata, 32'h1);
        chk("oneshot_irq_e5", 32'(irq), 32'h0);
        step();
        @(negedge clk);
        chk("oneshot_irq_e6", 32'(irq), 32'h1);
        step();
        addr = A_CTRL;
        @(negedge clk);
        chk("oneshot_autoclear", rdata, 32'h4);
        step();
        xfer(1, A_STAT, 32'h1, rd);
        xfer(1, A_CTRL, 32'h0, rd);

        // auto-reload: expiries at E+3, E+6, E+9
        xfer(1, A_LOAD, 32'd3, rd);
        xfer(1, A_CTRL, 32'h3, rd);
        step();
        xfer(1, A_STAT, 32'h1, rd);
        addr = A_STAT;
        @(negedge clk);
        chk("w1c_vs_expiry", rdata, 32'h3);
        step();
        xfer(1, A_LOAD, 32'd10, rd);
        xfer(1, A_STAT, 32'h1, rd);
        addr = A_STAT;
        @(negedge clk);
        chk("w1c_clear", rdata, 32'h2);
        step();
        addr = A_LOAD;
        @(negedge clk);
        chk("load_rewrite", rdata, 32'd10);
        step();
        xfer(1, A_CTRL, 32'h0, rd);

        // held request gets exactly one grant
        req = 1; write_en = 0; addr = A_STAT; ng = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (gnt === 1'b1) ng++;
            step();
            if (i == 11) req = 0;
        end
        chk("held_req_one_gnt", 32'(ng), 32'd1);

        // reset during WAIT drops the CONTROL write
        req = 1; write_en = 1; addr = A_CTRL; wdata = 32'h7; ng = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (gnt === 1'b1) ng++;
            step();
            if (i == 1) begin reset = 1; req = 0; write_en = 0; end
            if (i == 2) reset = 0;
        end
        chk("reset_wait_no_gnt", 32'(ng), 32'd0);
        xfer(0, A_CTRL, 32'h0, rd);
        chk("reset_wait_no_write", rd, 32'h0);

        for (int n = 0; n < 400; n++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 5) begin
                repeat ($urandom_range(1, 4)) begin
                    addr = 8'($urandom_range(0, 3) * 4);
                    write_en = 1'($urandom);
                    wdata = $urandom;
                    step();
                end
                write_en = 0;
            end else if (r < 8) begin
                logic [7:0] a;
                a = 8'($urandom_range(0, 3) * 4);
                xfer(1'($urandom), a,
                     (a == A_LOAD) ? 32'($urandom_range(0, 6)) : $urandom,
                     rd);
            end else if (r == 8) begin
                req = 1; addr = A_LOAD; write_en = 1; wdata = $urandom;
                repeat ($urandom_range(1, D - 1)) step();
                req = 0; write_en = 0;
                step();
            end else if ($urandom_range(0, 3) == 0) begin
                reset = 1;
                step();
                reset = 0;
            end else begin
                step();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
